alu_iter: RTL and testbench

Parametrised, pipelined successor to the single-cycle integer ALU. It is XLEN-generic and handles RV32I register/immediate arithmetic, shifts, compares and branch conditions, plus optional iterative RV32M multiply/divide. It sits between decode/register-read and writeback, with valid/ready handshakes on both sides and a single registered result slot.

---
 rtl/alu_iter.sv | 214 +++++++++++++++++++++
 tb/tb_alu_iter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_iter.sv
// alu_iter: pipelined XLEN ALU with one registered result slot.
// Define ALU_MULDIV_EN to add the iterative multiply/divide unit.
module alu_iter #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [XLEN-1:0] imm,
  input  logic            use_imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_SLL  = 5'd2;
  localparam logic [4:0] OP_SLT  = 5'd3;
  localparam logic [4:0] OP_SLTU = 5'd4;
  localparam logic [4:0] OP_XOR  = 5'd5;
  localparam logic [4:0] OP_SRL  = 5'd6;
  localparam logic [4:0] OP_SRA  = 5'd7;
  localparam logic [4:0] OP_OR   = 5'd8;
  localparam logic [4:0] OP_AND  = 5'd9;
  localparam logic [4:0] OP_EQ   = 5'd17;
  localparam logic [4:0] OP_NE   = 5'd18;
  localparam logic [4:0] OP_LT   = 5'd19;
  localparam logic [4:0] OP_GE   = 5'd20;
  localparam logic [4:0] OP_LTU  = 5'd21;
  localparam logic [4:0] OP_GEU  = 5'd22;
`ifdef ALU_MULDIV_EN
  localparam logic [4:0] OP_MUL   = 5'd10;
  localparam logic [4:0] OP_MULH  = 5'd11;
  localparam logic [4:0] OP_MULHU = 5'd12;
  localparam logic [4:0] OP_DIV   = 5'd13;
  localparam logic [4:0] OP_DIVU  = 5'd14;
  localparam logic [4:0] OP_REM   = 5'd15;
  localparam logic [4:0] OP_REMU  = 5'd16;
`endif

  logic [XLEN-1:0] opb;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] load_val;
  logic            accept;
  logic            load;

  assign opb    = use_imm ? imm : src2;
  assign accept = in_valid && in_ready;

  // single-cycle results, including the divide special cases
  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:  alu_res = src1 + opb;
      OP_SUB:  alu_res = src1 - opb;
      OP_SLL:  alu_res = src1 << opb[SHW-1:0];
      OP_SLT:  alu_res = XLEN'($signed(src1) < $signed(opb));
      OP_SLTU: alu_res = XLEN'(src1 < opb);
      OP_XOR:  alu_res = src1 ^ opb;
      OP_SRL:  alu_res = src1 >> opb[SHW-1:0];
      OP_SRA:  alu_res = $unsigned($signed(src1) >>> opb[SHW-1:0]);
      OP_OR:   alu_res = src1 | opb;
      OP_AND:  alu_res = src1 & opb;
      OP_EQ:   alu_res = XLEN'(src1 == opb);
      OP_NE:   alu_res = XLEN'(src1 != opb);
      OP_LT:   alu_res = XLEN'($signed(src1) < $signed(opb));
      OP_GE:   alu_res = XLEN'(!($signed(src1) < $signed(opb)));
      OP_LTU:  alu_res = XLEN'(src1 < opb);
      OP_GEU:  alu_res = XLEN'(!(src1 < opb));
`ifdef ALU_MULDIV_EN
      OP_DIV:  alu_res = (opb == '0) ? '1 : src1;
      OP_DIVU: alu_res = '1;
      OP_REM:  alu_res = (opb == '0) ? src1 : '0;
      OP_REMU: alu_res = src1;
`endif
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;

  localparam logic [SHW-1:0]  CNT_LAST = SHW'(XLEN - 1);
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state_q, state_d;
  logic [XLEN-1:0]   hi_q, lo_q, dv_q;
  logic [SHW-1:0]    cnt_q;
  logic              sel_q, neg_q;
  logic              is_mul, is_div, is_sgn, special, start;
  logic              sa, sb;
  logic [XLEN-1:0]   mag_a, mag_b;
  logic [XLEN:0]     mul_sum, div_try;
  logic [XLEN-1:0]   mul_hi, mul_lo, div_hi, div_lo;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   mul_res, div_sel, div_res;

  assign is_mul  = op inside {OP_MUL, OP_MULH, OP_MULHU};
  assign is_div  = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  assign is_sgn  = op inside {OP_MULH, OP_DIV, OP_REM};
  assign special = is_div && (opb == '0 ||
                   (is_sgn && src1 == SMIN && opb == '1));
  assign start   = accept && (is_mul || (is_div && !special));
  assign sa      = src1[XLEN-1];
  assign sb      = opb[XLEN-1];
  assign mag_a   = (is_sgn && sa) ? -src1 : src1;
  assign mag_b   = (is_sgn && sb) ? -opb : opb;

  // shift-add: {hi,lo} holds partial product over the multiplier
  assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : '0);
  assign mul_hi  = mul_sum[XLEN:1];
  assign mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
  assign prod    = neg_q ? -{mul_hi, mul_lo} : {mul_hi, mul_lo};
  assign mul_res = sel_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];

  // restoring divide: hi = partial remainder, lo = dividend/quotient
  assign div_try = {hi_q, lo_q[XLEN-1]} - {1'b0, dv_q};
  assign div_hi  = div_try[XLEN] ? {hi_q[XLEN-2:0], lo_q[XLEN-1]}
                                 : div_try[XLEN-1:0];
  assign div_lo  = {lo_q[XLEN-2:0], !div_try[XLEN]};
  assign div_sel = sel_q ? hi_q : lo_q;
  assign div_res = neg_q ? -div_sel : div_sel;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state and result-slot load selection
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    load_val = alu_res;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (start) state_d = is_mul ? MUL : DIV;
          else       load    = 1'b1;
        end
      end
      MUL: begin
        if (cnt_q == CNT_LAST) begin
          state_d  = IDLE;
          load     = 1'b1;
          load_val = mul_res;
        end
      end
      DIV: begin
        if (cnt_q == CNT_LAST) state_d = FIX;
      end
      FIX: begin
        state_d  = IDLE;
        load     = 1'b1;
        load_val = div_res;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready = (state_q == IDLE) && (!out_valid || out_ready);

  // iteration datapath: operand capture on start, one step per cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi_q  <= '0;
      lo_q  <= '0;
      dv_q  <= '0;
      cnt_q <= '0;
      sel_q <= 1'b0;
      neg_q <= 1'b0;
    end else if (start) begin
      hi_q  <= '0;
      lo_q  <= is_mul ? mag_b : mag_a;
      dv_q  <= is_mul ? mag_a : mag_b;
      cnt_q <= '0;
      sel_q <= !(op == OP_MUL || op == OP_DIV || op == OP_DIVU);
      neg_q <= (op == OP_REM) ? sa : (is_sgn && (sa ^ sb));
    end else if (state_q == MUL) begin
      hi_q  <= mul_hi;
      lo_q  <= mul_lo;
      cnt_q <= cnt_q + 1'b1;
    end else if (state_q == DIV) begin
      hi_q  <= div_hi;
      lo_q  <= div_lo;
      cnt_q <= cnt_q + 1'b1;
    end
  end
`else
  assign load     = accept;
  assign load_val = alu_res;
  assign in_ready = !out_valid || out_ready;
`endif

  // result slot: load wins over drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      result    <= load_val;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// tb_alu_iter: directed vectors for alu_iter.
// Expectations follow ALU_MULDIV_EN the same way the design does.
module tb_alu_iter;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic [XLEN-1:0] src1, src2, imm;
  logic            use_imm;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [4:0] ADD = 0, SUB = 1, SLL = 2, SLT = 3;
  localparam logic [4:0] SLTU = 4, XOR = 5, SRL = 6, SRA = 7;
  localparam logic [4:0] OR = 8, AND = 9, MUL = 10, MULH = 11;
  localparam logic [4:0] MULHU = 12, DIV = 13, DIVU = 14;
  localparam logic [4:0] REM = 15, REMU = 16, EQ = 17, NE = 18;
  localparam logic [4:0] LT = 19, GE = 20, LTU = 21, GEU = 22;

  alu_iter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .src1(src1), .src2(src2), .imm(imm),
    .use_imm(use_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] o,
                        input logic [31:0] a, input logic [31:0] bv,
                        input logic [31:0] iv, input logic ui,
                        input logic [31:0] exp, input int lat);
    int k;
    logic busy_bad;
    @(negedge clk);
    op = o; src1 = a; src2 = bv; imm = iv; use_imm = ui;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    src1 = $urandom; src2 = $urandom; imm = $urandom;
    k = 0;
    busy_bad = 1'b0;
    do begin
      @(negedge clk);
      k++;
      if (!out_valid && in_ready) busy_bad = 1'b1;
    end while (!out_valid && k < 200);
    check({tag, "_lat"}, k, lat);
    check({tag, "_res"}, result, exp);
    if (lat > 1) check({tag, "_busy"}, {31'd0, busy_bad}, 32'd0);
  endtask

  initial begin
    int sent, recv, cyc, errs;
    logic full, acc, stalled, prev_stall;
    logic [31:0] held;
    logic [31:0] exp_q [8];

    rst = 1'b1; in_valid = 1'b1; op = ADD;
    src1 = 32'd10; src2 = 32'd20; imm = '0; use_imm = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ov", {31'd0, out_valid}, 32'd0);
    check("rst_res", result, 32'd0);
    check("rst_rdy", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("first_ov", {31'd0, out_valid}, 32'd1);
    check("first_res", result, 32'd30);

    run_op("add_wrap", ADD, 32'hFFFF_FFFF, 32'd1, 32'd7, 0, 32'd0, 1);
    run_op("sra_imm", SRA, 32'h8000_0000, 32'd0, 32'd4, 1,
           32'hF800_0000, 1);
    run_op("sltu", SLTU, 32'd1, 32'hFFFF_FFFF, 0, 0, 32'd1, 1);
    run_op("slt", SLT, 32'd1, 32'hFFFF_FFFF, 0, 0, 32'd0, 1);
    run_op("sub", SUB, 32'd5, 32'd7, 0, 0, 32'hFFFF_FFFE, 1);
    run_op("sll_mask", SLL, 32'd1, 32'h21, 0, 0, 32'd2, 1);
    run_op("srl", SRL, 32'h8000_0000, 32'd4, 0, 0, 32'h0800_0000, 1);
    run_op("xor", XOR, 32'hF0F0, 32'hFF00, 0, 0, 32'h0FF0, 1);
    run_op("or", OR, 32'hF0F0, 32'hFF00, 0, 0, 32'hFFF0, 1);
    run_op("and", AND, 32'hF0F0, 32'hFF00, 0, 0, 32'hF000, 1);
    run_op("eq", EQ, 32'd5, 32'd5, 0, 0, 32'd1, 1);
    run_op("ne", NE, 32'd5, 32'd5, 0, 0, 32'd0, 1);
    run_op("lt", LT, 32'hFFFF_FFFF, 32'd0, 0, 0, 32'd1, 1);
    run_op("ge", GE, 32'hFFFF_FFFF, 32'd0, 0, 0, 32'd0, 1);
    run_op("ltu", LTU, 32'hFFFF_FFFF, 32'd0, 0, 0, 32'd0, 1);
    run_op("geu", GEU, 32'hFFFF_FFFF, 32'd0, 0, 0, 32'd1, 1);
    run_op("illegal", 5'd25, 32'd9, 32'd9, 0, 0, 32'd0, 1);
`ifdef ALU_MULDIV_EN
    run_op("mulh", MULH, 32'hFFFF_FFFD, 32'd7, 0, 0,
           32'hFFFF_FFFF, XLEN + 1);
    run_op("mul", MUL, 32'hFFFF_FFFD, 32'd7, 0, 0,
           32'hFFFF_FFEB, XLEN + 1);
    run_op("mulhu", MULHU, 32'hFFFF_FFFF, 32'd2, 0, 0,
           32'd1, XLEN + 1);
    run_op("div", DIV, 32'hFFFF_FFF9, 32'd2, 0, 0,
           32'hFFFF_FFFD, XLEN + 2);
    run_op("rem", REM, 32'hFFFF_FFF9, 32'd2, 0, 0,
           32'hFFFF_FFFF, XLEN + 2);
    run_op("remu", REMU, 32'd9, 32'd4, 0, 0, 32'd1, XLEN + 2);
    run_op("divu_z", DIVU, 32'd7, 32'd0, 0, 0, 32'hFFFF_FFFF, 1);
    run_op("rem_ovf", REM, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0,
           32'd0, 1);
    run_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0,
           32'h8000_0000, 1);
`else
    run_op("mulh_off", MULH, 32'hFFFF_FFFD, 32'd7, 0, 0, 32'd0, 1);
    run_op("mul_off", MUL, 32'hFFFF_FFFD, 32'd7, 0, 0, 32'd0, 1);
    run_op("divu_off", DIVU, 32'd7, 32'd0, 0, 0, 32'd0, 1);
    run_op("rem_off", REM, 32'hFFFF_FFF9, 32'd2, 0, 0, 32'd0, 1);
`endif

    // drain the slot before streaming
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);

    for (int i = 0; i < 8; i++) exp_q[i] = (i * 3 + 1) + (100 + i);
    sent = 0; recv = 0; cyc = 0; errs = 0;
    full = 1'b0; prev_stall = 1'b0; held = '0;
    while ((sent < 8 || full) && cyc < 100) begin
      @(negedge clk);
      out_ready = (cyc % 2 == 0);
      in_valid = (sent < 8);
      op = ADD; use_imm = 1'b0;
      src1 = sent * 3 + 1; src2 = 100 + sent;
      #1;
      if (out_valid !== full) errs++;
      if (in_ready !== (!full || out_ready)) errs++;
      if (prev_stall && result !== held) errs++;
      stalled = full && !out_ready;
      held = result;
      prev_stall = stalled;
      if (full && out_ready) begin
        check($sformatf("stream_%0d", recv), result, exp_q[recv]);
        recv++;
      end
      acc = in_valid && (!full || out_ready);
      full = acc || stalled;
      if (acc) sent++;
      cyc++;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    check("stream_hs", errs, 32'd0);
    check("stream_cnt", recv, 32'd8);

    errs = 0;
`ifdef ALU_MULDIV_EN
    @(negedge clk);
    op = DIV; src1 = 32'hFFFF_FF9C; src2 = 32'd7; use_imm = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) errs++;
    end
    rst = 1'b1;
    #1;
    check("abort_ov", {31'd0, out_valid}, 32'd0);
`else
    @(negedge clk);
    op = ADD; src1 = 32'd1; src2 = 32'd1; use_imm = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("hold_ov", {31'd0, out_valid}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("abort_ov", {31'd0, out_valid}, 32'd0);
`endif
    check("abort_res", result, 32'd0);
    check("abort_rdy", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) errs++;
    end
    check("abort_pulse", errs, 32'd0);
    run_op("post_rst", ADD, 32'd2, 32'd3, 0, 0, 32'd5, 1);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
